shift_ctrl: RTL and testbench

SHIFT_CTRL -- requirements
Module: shift_ctrl

---
 rtl/shift_ctrl.sv | 104 ++++++++++
 tb/tb_shift_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/shift_ctrl.sv
// Sequential 32-bit barrel shifter: five log-stages applied one per cycle (sll/srl/sra).
// Optional macro SHIFT_EARLY_EXIT_EN finishes as soon as no higher sh_amt bits remain.
module shift_ctrl (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] data_in,
  input  logic [4:0]  sh_amt,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_t;

  state_t      state_q;
  logic [1:0]  op_q;
  logic [4:0]  amt_q;
  logic [31:0] acc_q;
  logic [2:0]  cnt_q;
  logic        busy_q;
  logic        done_q;
  logic [31:0] result_q;

  logic        accept;
  logic [4:0]  step;
  logic [4:0]  amt_rem;
  logic [31:0] shifted;
  logic [31:0] stage_val;
  logic        last_stage;

  // A request is only taken when no shift is in flight; DONE may chain directly into SHIFT.
  assign accept = start && (state_q != StShift);

  always_comb begin
    step    = 5'd1 << cnt_q;
    amt_rem = amt_q >> cnt_q;
    shifted = acc_q << step;
    case (op_q)
      2'b01:   shifted = acc_q >> step;
      2'b10:   shifted = 32'($signed(acc_q) >>> step);
      default: shifted = acc_q << step;
    endcase
    stage_val = amt_rem[0] ? shifted : acc_q;
`ifdef SHIFT_EARLY_EXIT_EN
    last_stage = (amt_rem[4:1] == 4'd0);
`else
    last_stage = (cnt_q == 3'd4);
`endif
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      op_q     <= 2'b00;
      amt_q    <= 5'd0;
      acc_q    <= 32'd0;
      cnt_q    <= 3'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= 32'd0;
    end else if (accept) begin
      state_q <= StShift;
      op_q    <= op;
      amt_q   <= sh_amt;
      acc_q   <= data_in;
      cnt_q   <= 3'd0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        StShift: begin
          acc_q <= stage_val;
          cnt_q <= cnt_q + 3'd1;
          if (last_stage) begin
            state_q  <= StDone;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            result_q <= stage_val;
          end
        end
        StDone: begin
          state_q <= StIdle;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_shift_ctrl.sv
// Randomised self-checking bench for shift_ctrl against a shift-operator reference model.
module tb_shift_ctrl;

  logic        clock;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] data_in;
  logic [4:0]  sh_amt;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int n_checks = 0;
  int n_pass   = 0;

  shift_ctrl dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .data_in (data_in),
    .sh_amt  (sh_amt),
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic logic [31:0] ref_shift(input logic [1:0] o, input logic [31:0] d,
                                             input logic [4:0] a);
    logic signed [31:0] sd;
    sd = d;
    case (o)
      2'b01:   return d >> a;
      2'b10:   return sd >>> a;
      default: return d << a;
    endcase
  endfunction

  // Edges from the accepting edge to the one raising done.
  function automatic int ref_latency(input logic [4:0] a);
    int lat;
`ifdef SHIFT_EARLY_EXIT_EN
    lat = 1;
    for (int i = 0; i < 5; i++) if (a[i]) lat = i + 1;
`else
    lat = 5;
`endif
    return lat;
  endfunction

  task automatic wait_done(output int cyc);
    cyc = 0;
    do begin
      @(posedge clock);
      #1;
      cyc++;
    end while (!done && cyc < 12);
  endtask

  task automatic do_shift(input logic [1:0] o, input logic [31:0] d, input logic [4:0] a);
    int cyc;
    logic [31:0] exp;
    exp = ref_shift(o, d, a);
    @(negedge clock);
    start = 1'b1; op = o; data_in = d; sh_amt = a;
    @(posedge clock);
    #1;
    check("busy_after_start", 32'(busy), 32'd1);
    @(negedge clock);
    // Scrambled inputs must not disturb the operation in flight.
    start = 1'b0; op = 2'($urandom); data_in = $urandom; sh_amt = 5'($urandom);
    wait_done(cyc);
    check("done_latency", 32'(cyc), 32'(ref_latency(a)));
    check("result", result, exp);
    check("busy_at_done", 32'(busy), 32'd0);
    @(posedge clock);
    #1;
    check("done_one_cycle", 32'(done), 32'd0);
    check("result_held", result, exp);
  endtask

  initial begin
    int cyc;
    reset = 1'b1; start = 1'b0; op = 2'b00; data_in = 32'd0; sh_amt = 5'd0;
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_result", result, 32'd0);
    @(negedge clock);
    reset = 1'b0;

    do_shift(2'b00, 32'h0000_0001, 5'd31);
    check("sll_31_value", result, 32'h8000_0000);
    do_shift(2'b10, 32'h8000_0000, 5'd4);
    check("sra_4_value", result, 32'hF800_0000);
    do_shift(2'b01, 32'h8000_0000, 5'd4);
    check("srl_4_value", result, 32'h0800_0000);
    do_shift(2'b11, 32'h8000_0000, 5'd4);
    check("rsv_4_value", result, 32'h0000_0000);
    do_shift(2'b00, 32'hDEAD_BEEF, 5'd0);
    check("amt0_value", result, 32'hDEAD_BEEF);
    do_shift(2'b01, 32'hF000_000F, 5'd3);

    // Second start while busy is ignored; a start during DONE chains directly.
    @(negedge clock);
    start = 1'b1; op = 2'b00; data_in = 32'h0000_00FF; sh_amt = 5'd8;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    @(posedge clock);
    @(negedge clock);
    start = 1'b1; data_in = 32'h1234_5678; sh_amt = 5'd1; op = 2'b01;
    @(posedge clock);
    #1;
    check("collide_busy", 32'(busy), 32'd1);
    @(negedge clock);
    start = 1'b0;
    wait_done(cyc);
    check("collide_latency", 32'(cyc + 2), 32'(ref_latency(5'd8)));
    check("collide_result", result, 32'h0000_FF00);
    @(negedge clock);
    start = 1'b1; op = 2'b10; data_in = 32'h8000_0000; sh_amt = 5'd4;
    @(posedge clock);
    #1;
    check("b2b_busy", 32'(busy), 32'd1);
    check("b2b_done", 32'(done), 32'd0);
    @(negedge clock);
    start = 1'b0;
    wait_done(cyc);
    check("b2b_latency", 32'(cyc), 32'(ref_latency(5'd4)));
    check("b2b_result", result, 32'hF800_0000);

    // Reset between t2 and t3 abandons the shift immediately.
    @(negedge clock);
    start = 1'b1; op = 2'b00; data_in = 32'h0000_0001; sh_amt = 5'd31;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", result, 32'd0);
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    #1;
    check("start_in_reset", 32'(busy), 32'd0);
    @(negedge clock);
    start = 1'b0; reset = 1'b0;
    cyc = 0;
    for (int i = 0; i < 7; i++) begin
      @(posedge clock);
      #1;
      if (done || busy) cyc++;
    end
    check("rst_no_activity", 32'(cyc), 32'd0);
    do_shift(2'b00, 32'h0000_0001, 5'd1);
    check("post_rst_value", result, 32'h0000_0002);

    for (int n = 0; n < 1000; n++) begin
      do_shift(2'($urandom), $urandom, 5'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
